operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Front-panel input controller. Converts debounced push-button pulses into the two 16-bit hex operands and sequences the calculator through its modes.
- Drives `operandA`, `operandB`, `chosen_operand` and `display_mode` to the 7-segment display block, and issues a start pulse to the ALU.
- Waits for the ALU result before entering result display.

Parameters:
- TIMEOUT_CYCLES, 1000: maximum cycles in WAIT_RES before forcing result display with `err` set.
- OPERAND_A, 2'b01: `chosen_operand` encoding for operand A.
- OPERAND_B, 2'b10: `chosen_operand` encoding for operand B.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_up  input  1  increment the nibble under the cursor (one-cycle pulse).
- btn_down  input  1  decrement the nibble under the cursor (one-cycle pulse).
- btn_left  input  1  move the cursor one nibble towards the MSB (one-cycle pulse).
- btn_right  input  1  move the cursor one nibble towards the LSB (one-cycle pulse).
- btn_center  input  1  confirm / advance state (one-cycle pulse).
- result_valid  input  1  ALU result ready (level or pulse).
- operandA  output  16  operand A value.
- operandB  output  16  operand B value.
- chosen_operand  output  2  OPERAND_A, OPERAND_B or 2'b00.
- display_mode  output  2  00 blank, 01 operand, 10 result.
- cursor  output  2  nibble index being edited (0 = bits 3:0).
- start  output  1  one-cycle ALU start pulse.
- err  output  1  result timed out.

Behaviour:
- Reset (reset low, asynchronous):
  - `operandA`, `operandB`, `cursor`, `chosen_operand`, `display_mode`, `start`, `err` all 0; timeout counter 0; state IDLE.
  - Reset asserted mid-edit discards the operands.
- States and their outputs:
  - IDLE: `display_mode` 00, `chosen_operand` 00.
  - EDIT_A: `display_mode` 01, `chosen_operand` OPERAND_A.
  - EDIT_B: `display_mode` 01, `chosen_operand` OPERAND_B.
  - WAIT_RES: `display_mode` 00, `chosen_operand` 00.
  - SHOW_RES: `display_mode` 10, `chosen_operand` 00.
  - All outputs are registered; a state change is visible on the cycle after the button pulse.
- Transitions on `btn_center`:
  - IDLE -> EDIT_A.
  - EDIT_A -> EDIT_B; `cursor` resets to 0.
  - EDIT_B -> WAIT_RES; `start` = 1 for exactly the first cycle in WAIT_RES; timeout counter cleared.
  - SHOW_RES -> EDIT_A; operands retained, `err` cleared.
  - `btn_center` in WAIT_RES is ignored.
- WAIT_RES exit:
  - `result_valid` = 1 -> SHOW_RES.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 -> SHOW_RES with `err` = 1.
  - `result_valid` and timeout in the same cycle: `result_valid` wins, `err` stays 0.
  - `result_valid` outside WAIT_RES is ignored.
- Editing (EDIT_A/EDIT_B only):
  - Up/down act on nibble `operandX[4*cursor+3 : 4*cursor]`, modulo 16: F+1 -> 0, 0-1 -> F. Other nibbles are unchanged.
  - Left: `cursor` +1 mod 4, so 3 -> 0.
  - Right: `cursor` -1 mod 4, so 0 -> 3.
  - Buttons other than center are ignored in IDLE, WAIT_RES and SHOW_RES.
- Simultaneous pulses: exactly one action per cycle, priority center > up > down > left > right.

Optional Feature:
- Macro: OPERAND_ENTRY_BTN_EDGE_EN.
- Defined: each `btn_*` input passes through a 2-flop synchronizer plus a rising-edge detector, so level (held) buttons produce one action per press. This adds 2 cycles of input latency.
- Undefined: inputs are used directly as single-cycle pulses; a held level repeats the action every cycle.

Decomposition:
- Shared package `calc_pkg` holds:
  - state encoding constants: IDLE, EDIT_A, EDIT_B, WAIT_RES, SHOW_RES;
  - OPERAND_A / OPERAND_B codes;
  - DISP_BLANK = 00, DISP_OPERAND = 01, DISP_RESULT = 10.
- One natural sub-module, `btn_edge`: synchronizer plus rising-edge detector, instantiated 5× only when the macro is defined.

Test Plan:
- Reset: release `reset` -> all outputs 0, `display_mode` = 00; assert `reset` while in EDIT_A with `operandA` = 0x0003 -> `operandA` = 0 immediately (asynchronous).
- Nibble wrap: center, then 17× up at cursor 0 -> `operandA` = 0x0001; down at 0x0000 -> 0x000F.
- Cursor wrap and nibble edit: in EDIT_A, left ×3 then up -> `operandA` = 0x1000; left once more -> `cursor` = 0; right at `cursor` 0 -> `cursor` = 3.
- Full sequence: A = 0x0012, center, B = 0x0034, center -> `start` high exactly 1 cycle, `display_mode` = 00; `result_valid` -> `display_mode` = 10 next cycle; center -> EDIT_A with `operandA` still 0x0012.
- Timeout: no `result_valid` for TIMEOUT_CYCLES (e.g. set to 8) -> `display_mode` = 10 and `err` = 1; `result_valid` on the timeout cycle -> `err` = 0.
- Priority: up and left in the same cycle -> only the nibble increments; `cursor` unchanged.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: controller states, operand-select and display-mode codes,
// and the nibble step helper used while editing operands.
package calc_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EDIT_A   = 3'd1,
      EDIT_B   = 3'd2,
      WAIT_RES = 3'd3,
      SHOW_RES = 3'd4
   } state_t;

   localparam logic [1:0] OPERAND_A    = 2'b01;
   localparam logic [1:0] OPERAND_B    = 2'b10;
   localparam logic [1:0] OPERAND_NONE = 2'b00;

   localparam logic [1:0] DISP_BLANK   = 2'b00;
   localparam logic [1:0] DISP_OPERAND = 2'b01;
   localparam logic [1:0] DISP_RESULT  = 2'b10;

   typedef struct packed {
      logic center;
      logic up;
      logic down;
      logic left;
      logic right;
   } btn_t;

   // Step one nibble of a 16-bit operand by +/-1, wrapping within the nibble.
   function automatic logic [15:0] nibble_step(input logic [15:0] val,
                                               input logic [1:0]  idx,
                                               input logic        dec);
      logic [15:0] res;
      logic [3:0]  nib;
      res = val;
      nib = val[4*idx +: 4];
      res[4*idx +: 4] = dec ? nib - 4'd1 : nib + 4'd1;
      return res;
   endfunction

endpackage

// File: rtl/operand_entry_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; turns a held
// button level into a single-cycle pulse, two cycles after the press.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic [2:0] sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= '0;
      else        sync <= {sync[1:0], din};
   end

   assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/operand_entry.sv
// Front-panel operand entry controller: edits two hex operands, starts the ALU
// and waits for its result. Define OPERAND_ENTRY_BTN_EDGE_EN to edge-detect held buttons.
module operand_entry #(
   parameter int         TIMEOUT_CYCLES = 1000,
   parameter logic [1:0] OPERAND_A      = 2'b01,
   parameter logic [1:0] OPERAND_B      = 2'b10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_center,
   input  logic        result_valid,
   output logic [15:0] operandA,
   output logic [15:0] operandB,
   output logic [1:0]  chosen_operand,
   output logic [1:0]  display_mode,
   output logic [1:0]  cursor,
   output logic        start,
   output logic        err
);

   import calc_pkg::*;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t      state;
   logic [CW-1:0] tmo_cnt;
   logic [4:0]  btn_raw;
   btn_t        btn;
   logic [15:0] cur_op;
   logic [15:0] edit_op;

   assign btn_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

`ifdef OPERAND_ENTRY_BTN_EDGE_EN
   logic [4:0] btn_pulse;
   for (genvar i = 0; i < 5; i++) begin : g_edge
      btn_edge u_edge (
         .clk   (clk),
         .reset (reset),
         .din   (btn_raw[i]),
         .pulse (btn_pulse[i])
      );
   end
   assign btn = btn_t'(btn_pulse);
`else
   assign btn = btn_t'(btn_raw);
`endif

   // Nibble edit applies to whichever operand is currently selected.
   always_comb begin
      cur_op  = (state == EDIT_B) ? operandB : operandA;
      edit_op = nibble_step(cur_op, cursor, btn.down & ~btn.up);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         operandA       <= '0;
         operandB       <= '0;
         cursor         <= '0;
         chosen_operand <= OPERAND_NONE;
         display_mode   <= DISP_BLANK;
         start          <= 1'b0;
         err            <= 1'b0;
         tmo_cnt        <= '0;
      end else begin
         start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (btn.center) begin
                  state          <= EDIT_A;
                  display_mode   <= DISP_OPERAND;
                  chosen_operand <= OPERAND_A;
               end
            end
            EDIT_A, EDIT_B: begin
               if (btn.center) begin
                  if (state == EDIT_A) begin
                     state          <= EDIT_B;
                     cursor         <= '0;
                     chosen_operand <= OPERAND_B;
                  end else begin
                     state          <= WAIT_RES;
                     start          <= 1'b1;
                     tmo_cnt        <= '0;
                     display_mode   <= DISP_BLANK;
                     chosen_operand <= OPERAND_NONE;
                  end
               end else if (btn.up || btn.down) begin
                  if (state == EDIT_A) operandA <= edit_op;
                  else                 operandB <= edit_op;
               end else if (btn.left) begin
                  cursor <= cursor + 2'd1;
               end else if (btn.right) begin
                  cursor <= cursor - 2'd1;
               end
            end
            WAIT_RES: begin
               // A result arriving on the timeout cycle still counts as success.
               if (result_valid) begin
                  state        <= SHOW_RES;
                  display_mode <= DISP_RESULT;
                  err          <= 1'b0;
               end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state        <= SHOW_RES;
                  display_mode <= DISP_RESULT;
                  err          <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            SHOW_RES: begin
               if (btn.center) begin
                  state          <= EDIT_A;
                  err            <= 1'b0;
                  display_mode   <= DISP_OPERAND;
                  chosen_operand <= OPERAND_A;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed vector table, hand-written
// corner sequences, and randomized buttons against a behavioural model.
module tb_operand_entry;

   localparam int T = 8;
   localparam logic [4:0] C = 5'b10000, U = 5'b01000, D = 5'b00100,
                          L = 5'b00010, R = 5'b00001, N = 5'b00000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_center = 0;
   logic result_valid = 0;
   logic [15:0] operandA, operandB;
   logic [1:0]  chosen_operand, display_mode, cursor;
   logic        start, err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   operand_entry #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_center(btn_center),
      .result_valid(result_valid),
      .operandA(operandA), .operandB(operandB),
      .chosen_operand(chosen_operand), .display_mode(display_mode),
      .cursor(cursor), .start(start), .err(err)
   );

   // Behavioural model: mode 0 idle, 1 edit A, 2 edit B, 3 waiting, 4 showing result.
   int          m_mode;
   logic [15:0] m_a, m_b;
   int          m_cur;
   bit          m_start, m_err;
   int          m_waited;

   function automatic void model_reset();
      m_mode = 0; m_a = 0; m_b = 0; m_cur = 0;
      m_start = 0; m_err = 0; m_waited = 0;
   endfunction

   function automatic logic [15:0] bump(input logic [15:0] v, input int pos, input bit inc);
      int nib;
      nib = (int'(v) >> (4 * pos)) & 15;
      nib = inc ? (nib + 1) % 16 : (nib + 15) % 16;
      return (v & ~(16'hF << (4 * pos))) | 16'(nib << (4 * pos));
   endfunction

   function automatic void model_step(input logic [4:0] b, input logic rv);
      bit c, u, d, l, r;
      {c, u, d, l, r} = b;
      m_start = 0;
      case (m_mode)
         0: if (c) m_mode = 1;
         1, 2: begin
            if (c) begin
               if (m_mode == 1) begin m_mode = 2; m_cur = 0; end
               else begin m_mode = 3; m_start = 1; m_waited = 0; end
            end else if (u || d) begin
               if (m_mode == 1) m_a = bump(m_a, m_cur, u);
               else             m_b = bump(m_b, m_cur, u);
            end else if (l) m_cur = (m_cur + 1) % 4;
            else if (r)     m_cur = (m_cur + 3) % 4;
         end
         3: begin
            m_waited++;
            if (rv) begin m_mode = 4; m_err = 0; end
            else if (m_waited == T) begin m_mode = 4; m_err = 1; end
         end
         4: if (c) begin m_mode = 1; m_err = 0; end
         default: ;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      logic [1:0] emode, ech;
      emode = (m_mode == 1 || m_mode == 2) ? 2'd1 : (m_mode == 4 ? 2'd2 : 2'd0);
      ech   = (m_mode == 1) ? 2'd1 : (m_mode == 2 ? 2'd2 : 2'd0);
      check({tag, ".A"},    operandA, m_a);
      check({tag, ".B"},    operandB, m_b);
      check({tag, ".cur"},  16'(cursor), 16'(m_cur));
      check({tag, ".mode"}, 16'(display_mode), 16'(emode));
      check({tag, ".ch"},   16'(chosen_operand), 16'(ech));
      check({tag, ".start"}, 16'(start), 16'(m_start));
      check({tag, ".err"},  16'(err), 16'(m_err));
   endtask

   // One clock: inputs present for exactly one rising edge, then cleared.
   task automatic cyc(input logic [4:0] b, input logic rv);
      {btn_center, btn_up, btn_down, btn_left, btn_right} = b;
      result_valid = rv;
      @(posedge clk);
      model_step(b, rv);
      #1;
      {btn_center, btn_up, btn_down, btn_left, btn_right} = 5'b0;
      result_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic [4:0]  b;
      logic        rv;
      logic [15:0] a, bb;
      logic [1:0]  cur, mode, ch;
      logic        st, er;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [4:0] b, input logic rv, input logic [15:0] a,
                               input logic [15:0] bb, input logic [1:0] cur,
                               input logic [1:0] mode, input logic [1:0] ch,
                               input logic st, input logic er);
      vec_t v;
      v.b = b; v.rv = rv; v.a = a; v.bb = bb; v.cur = cur;
      v.mode = mode; v.ch = ch; v.st = st; v.er = er;
      tbl.push_back(v);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //   btn     rv  A        B        cur mode ch st er
      add(C,       0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0);
      add(U,       0, 16'h0001, 16'h0000, 0, 1, 1, 0, 0);
      add(U | L,   0, 16'h0002, 16'h0000, 0, 1, 1, 0, 0);
      add(L,       0, 16'h0002, 16'h0000, 1, 1, 1, 0, 0);
      add(U,       0, 16'h0012, 16'h0000, 1, 1, 1, 0, 0);
      add(R,       0, 16'h0012, 16'h0000, 0, 1, 1, 0, 0);
      add(D,       0, 16'h0011, 16'h0000, 0, 1, 1, 0, 0);
      add(U,       0, 16'h0012, 16'h0000, 0, 1, 1, 0, 0);
      add(C,       0, 16'h0012, 16'h0000, 0, 1, 2, 0, 0);
      add(N,       1, 16'h0012, 16'h0000, 0, 1, 2, 0, 0);
      add(U,       0, 16'h0012, 16'h0001, 0, 1, 2, 0, 0);
      add(U,       0, 16'h0012, 16'h0002, 0, 1, 2, 0, 0);
      add(U,       0, 16'h0012, 16'h0003, 0, 1, 2, 0, 0);
      add(U,       0, 16'h0012, 16'h0004, 0, 1, 2, 0, 0);
      add(L,       0, 16'h0012, 16'h0004, 1, 1, 2, 0, 0);
      add(U,       0, 16'h0012, 16'h0014, 1, 1, 2, 0, 0);
      add(U,       0, 16'h0012, 16'h0024, 1, 1, 2, 0, 0);
      add(U,       0, 16'h0012, 16'h0034, 1, 1, 2, 0, 0);
      add(R,       0, 16'h0012, 16'h0034, 0, 1, 2, 0, 0);
      add(C,       0, 16'h0012, 16'h0034, 0, 0, 0, 1, 0);
      add(N,       0, 16'h0012, 16'h0034, 0, 0, 0, 0, 0);
      add(U | L,   0, 16'h0012, 16'h0034, 0, 0, 0, 0, 0);
      add(N,       1, 16'h0012, 16'h0034, 0, 2, 0, 0, 0);
      add(U,       0, 16'h0012, 16'h0034, 0, 2, 0, 0, 0);
      add(C,       0, 16'h0012, 16'h0034, 0, 1, 1, 0, 0);
      add(C | U,   0, 16'h0012, 16'h0034, 0, 1, 2, 0, 0);

      // Reset state
      model_reset();
      repeat (2) @(negedge clk);
      check("rst.A", operandA, 16'h0);
      check("rst.B", operandB, 16'h0);
      check("rst.mode", 16'(display_mode), 16'h0);
      check("rst.ch", 16'(chosen_operand), 16'h0);
      check("rst.cur", 16'(cursor), 16'h0);
      check("rst.start", 16'(start), 16'h0);
      check("rst.err", 16'(err), 16'h0);
      reset = 1'b1;
      @(negedge clk);
      check("idle.mode", 16'(display_mode), 16'h0);

      // Directed table
      foreach (tbl[i]) begin
         cyc(tbl[i].b, tbl[i].rv);
         check($sformatf("vec%0d.A", i), operandA, tbl[i].a);
         check($sformatf("vec%0d.B", i), operandB, tbl[i].bb);
         check($sformatf("vec%0d.cur", i), 16'(cursor), 16'(tbl[i].cur));
         check($sformatf("vec%0d.mode", i), 16'(display_mode), 16'(tbl[i].mode));
         check($sformatf("vec%0d.ch", i), 16'(chosen_operand), 16'(tbl[i].ch));
         check($sformatf("vec%0d.start", i), 16'(start), 16'(tbl[i].st));
         check($sformatf("vec%0d.err", i), 16'(err), 16'(tbl[i].er));
      end

      // Nibble wrap
      do_reset();
      cyc(C, 0);
      repeat (17) cyc(U, 0);
      check("wrap.up17", operandA, 16'h0001);
      cyc(D, 0);
      check("wrap.to0", operandA, 16'h0000);
      cyc(D, 0);
      check("wrap.down", operandA, 16'h000F);

      // Cursor wrap and upper nibble edit
      do_reset();
      cyc(C, 0);
      repeat (3) cyc(L, 0);
      cyc(U, 0);
      check("cur.nib3", operandA, 16'h1000);
      check("cur.is3", 16'(cursor), 16'd3);
      cyc(L, 0);
      check("cur.left_wrap", 16'(cursor), 16'd0);
      cyc(R, 0);
      check("cur.right_wrap", 16'(cursor), 16'd3);

      // Asynchronous reset mid-edit
      do_reset();
      cyc(C, 0);
      repeat (3) cyc(U, 0);
      check("arst.pre", operandA, 16'h0003);
      #2 reset = 1'b0;
      #1;
      check("arst.A", operandA, 16'h0000);
      check("arst.mode", 16'(display_mode), 16'h0);
      check("arst.ch", 16'(chosen_operand), 16'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      // Timeout forcing result display with err
      cyc(C, 0); cyc(C, 0); cyc(C, 0);
      check("tmo.start", 16'(start), 16'd1);
      for (int k = 0; k < T - 1; k++) begin
         cyc((k == 0) ? C : N, 0);
         check("tmo.waiting", 16'(display_mode), 16'd0);
         check("tmo.no_err", 16'(err), 16'd0);
      end
      cyc(N, 0);
      check("tmo.mode", 16'(display_mode), 16'd2);
      check("tmo.err", 16'(err), 16'd1);
      cyc(C, 0);
      check("tmo.clr_err", 16'(err), 16'd0);
      check("tmo.edit_a", 16'(chosen_operand), 16'd1);

      // Result arriving on the timeout cycle wins
      cyc(C, 0); cyc(C, 0);
      repeat (T - 1) cyc(N, 0);
      check("tie.waiting", 16'(display_mode), 16'd0);
      cyc(N, 1);
      check("tie.mode", 16'(display_mode), 16'd2);
      check("tie.err", 16'(err), 16'd0);

      // Randomized stimulus against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] b;
         logic rv;
         for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 5) == 0);
         rv = ($urandom_range(0, 5) == 0);
         cyc(b, rv);
         check_model($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
